// File: rtl/nanov_shift_seq.sv
// nanov_shift_seq -- sequencer for a bit-serial RISC-V shifter.
//
// The block owns the operand registers of an external serial shifter and
// steps it through 32 bit positions. Each RUN cycle the shifter returns one
// result bit (sh_d) and optionally asks for the working A register to be
// shifted right with a fill bit. Shift direction and sign handling live
// entirely in the shifter. The sequencer only counts and collects bits.
//
// Ports
//   clk         single clock, rising edge
//   rstn        asynchronous active-low reset
//   start       request; sampled only in IDLE or DONE
//   op_in[3:0]  0001 SLL, 0101 SRL, 1101 SRA (op_in[1:0] must be 01)
//   a_in[31:0]  operand A, captured on an accepted start
//   b_in[4:0]   shift amount, captured on an accepted start
//   sh_op       registered op           -> shifter op
//   sh_counter  bit index 0..31         -> shifter counter
//   sh_a        working A register      -> shifter a
//   sh_b        registered shift amount -> shifter b
//   sh_d        serial result bit       <- shifter
//   sh_shift_a  shift working A request <- shifter
//   sh_top_bit  fill bit for working A  <- shifter
//   busy        high while in RUN
//   done        one-cycle pulse while in DONE; result is final
//   result      shifted value, held until the next accepted start
//
// Handshake: a start is accepted on a rising edge when the block is in IDLE
// or DONE, start=1 and op_in[1:0]=01. start is ignored in RUN. done is high
// for exactly one cycle, 32 edges after the accepting edge, and result is
// valid from that cycle until the next accepted start.
//
// Option macro: NANOV_SHIFT_ZERO_FAST_EN -- when defined, an accepted start
// with b_in=0 skips RUN, loads result=a_in and goes directly to DONE.

module nanov_shift_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [3:0]  op_in,
  input  logic [31:0] a_in,
  input  logic [4:0]  b_in,
  output logic [3:0]  sh_op,
  output logic [4:0]  sh_counter,
  output logic [31:0] sh_a,
  output logic [4:0]  sh_b,
  input  logic        sh_d,
  input  logic        sh_shift_a,
  input  logic        sh_top_bit,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  op_nx;
  logic [4:0]  counter_nx;
  logic [31:0] a_nx;
  logic [4:0]  b_nx;
  logic [31:0] result_nx;
  logic        accept;

  // Only shift opcodes (low bits 01) are taken; anything else is dropped.
  assign accept = start && (op_in[1:0] == 2'b01);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      sh_op      <= 4'd0;
      sh_counter <= 5'd0;
      sh_a       <= 32'd0;
      sh_b       <= 5'd0;
      result     <= 32'd0;
    end else begin
      state      <= state_nx;
      sh_op      <= op_nx;
      sh_counter <= counter_nx;
      sh_a       <= a_nx;
      sh_b       <= b_nx;
      result     <= result_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    op_nx      = sh_op;
    counter_nx = sh_counter;
    a_nx       = sh_a;
    b_nx       = sh_b;
    result_nx  = result;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          op_nx      = op_in;
          a_nx       = a_in;
          b_nx       = b_in;
          counter_nx = 5'd0;
`ifdef NANOV_SHIFT_ZERO_FAST_EN
          if (b_in == 5'd0) begin
            result_nx = a_in;
            state_nx  = ST_DONE;
          end else begin
            result_nx = 32'd0;
            state_nx  = ST_RUN;
          end
`else
          result_nx = 32'd0;
          state_nx  = ST_RUN;
`endif
        end else begin
          // DONE lasts one cycle; a rejected start behaves like no start.
          state_nx = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Bits arrive LSB first: the bit taken at counter k ends in result[k].
        result_nx  = {sh_d, result[31:1]};
        if (sh_shift_a) begin
          a_nx = {sh_top_bit, sh_a[31:1]};
        end
        counter_nx = sh_counter + 5'd1;
        if (sh_counter == 5'd31) begin
          state_nx = ST_DONE;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_nanov_shift_seq.sv
// tb_nanov_shift_seq -- directed bench for nanov_shift_seq.
//
// A small behavioural serial shifter is attached to the sh_* ports:
//   right shifts: shift working A every cycle, fill with sign (SRA) or 0,
//                 result bit = sh_a[sh_b]
//   left shift:   shift working A once counter >= sh_b, result bit = sh_a[0],
//                 zero before that
// Expected results and latencies are hand-computed constants.

module tb_nanov_shift_seq;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [3:0]  op_in;
  logic [31:0] a_in;
  logic [4:0]  b_in;
  logic [3:0]  sh_op;
  logic [4:0]  sh_counter;
  logic [31:0] sh_a;
  logic [4:0]  sh_b;
  logic        sh_d;
  logic        sh_shift_a;
  logic        sh_top_bit;
  logic        busy;
  logic        done;
  logic [31:0] result;

  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b1101;

`ifdef NANOV_SHIFT_ZERO_FAST_EN
  localparam int ZERO_LAT  = 1;
  localparam logic ZERO_BUSY = 1'b0;
`else
  localparam int ZERO_LAT  = 33;
  localparam logic ZERO_BUSY = 1'b1;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  nanov_shift_seq dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .op_in      (op_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .sh_op      (sh_op),
    .sh_counter (sh_counter),
    .sh_a       (sh_a),
    .sh_b       (sh_b),
    .sh_d       (sh_d),
    .sh_shift_a (sh_shift_a),
    .sh_top_bit (sh_top_bit),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural serial shifter
  always_comb begin
    sh_shift_a = 1'b0;
    sh_top_bit = 1'b0;
    sh_d       = 1'b0;
    if (sh_op[2]) begin
      sh_shift_a = 1'b1;
      sh_top_bit = sh_op[3] & sh_a[31];
      sh_d       = sh_a[sh_b];
    end else if (sh_counter >= sh_b) begin
      sh_shift_a = 1'b1;
      sh_d       = sh_a[0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at #1 after the accepting edge (count 1); returns the number of
  // edges counted from the accepting edge up to the one that raised done.
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // Called at a negedge.
  task automatic drive_start(input logic [3:0] op, input logic [31:0] a, input logic [4:0] b);
    op_in = op;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [4:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input logic exp_busy);
    int k;
    logic [31:0] e;
    exp_q.push_back(exp_res);
    @(negedge clk);
    drive_start(op, a, b);
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
    wait_done(1, k);
    check({tag, "_lat"}, k, exp_lat);
    e = exp_q.pop_front();
    check({tag, "_res"}, result, e);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, result, e);
  endtask

  initial begin
    int k;
    rstn  = 1'b0;
    start = 1'b0;
    op_in = 4'd0;
    a_in  = 32'd0;
    b_in  = 5'd0;

    // reset state, before any clock edge
    #3;
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_done",    {31'd0, done}, 32'd0);
    check("rst_result",  result, 32'd0);
    check("rst_sh_a",    sh_a, 32'd0);
    check("rst_counter", {27'd0, sh_counter}, 32'd0);
    check("rst_op_b",    {23'd0, sh_op, sh_b}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // basic shifts
    run_op("sll_1_4",    OP_SLL, 32'h0000_0001, 5'd4,  32'h0000_0010, 33, 1'b1);
    run_op("sra_8_31",   OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 33, 1'b1);
    run_op("srl_8_31",   OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 33, 1'b1);
    run_op("sra_f0_4",   OP_SRA, 32'hF000_000F, 5'd4,  32'hFF00_0000, 33, 1'b1);
    run_op("sll_a5_31",  OP_SLL, 32'hA5A5_A5A5, 5'd31, 32'h8000_0000, 33, 1'b1);

    // start during RUN is ignored
    @(negedge clk);
    drive_start(OP_SRL, 32'hDEAD_BEEF, 5'd8);
    repeat (10) @(posedge clk);
    @(negedge clk);
    drive_start(OP_SLL, 32'h0000_0000, 5'd0);
    check("ign_busy",    {31'd0, busy}, 32'd1);
    check("ign_counter", {27'd0, sh_counter}, 32'd11);
    wait_done(12, k);
    check("ign_lat", k, 33);
    check("ign_res", result, 32'h00DE_ADBE);
    @(posedge clk); #1;

    // reset in the middle of RUN
    @(negedge clk);
    drive_start(OP_SLL, 32'h0000_FFFF, 5'd3);
    repeat (14) @(posedge clk);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("ab_busy",    {31'd0, busy}, 32'd0);
    check("ab_done",    {31'd0, done}, 32'd0);
    check("ab_result",  result, 32'd0);
    check("ab_sh_a",    sh_a, 32'd0);
    check("ab_counter", {27'd0, sh_counter}, 32'd0);
    check("ab_op_b",    {23'd0, sh_op, sh_b}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("ab_done_held", {31'd0, done}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    drive_start(OP_SLL, 32'h0000_0003, 5'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd1);
    wait_done(1, k);
    check("post_rst_lat", k, 33);
    check("post_rst_res", result, 32'h0000_0006);
    @(posedge clk); #1;

    // invalid opcodes are rejected
    @(negedge clk);
    drive_start(4'b0000, 32'hFFFF_FFFF, 5'd2);
    check("rej0_busy", {31'd0, busy}, 32'd0);
    check("rej0_done", {31'd0, done}, 32'd0);
    check("rej0_res",  result, 32'h0000_0006);
    @(negedge clk);
    drive_start(4'b0011, 32'hFFFF_FFFF, 5'd2);
    check("rej3_busy", {31'd0, busy}, 32'd0);
    check("rej3_res",  result, 32'h0000_0006);

    // zero shift amount
    run_op("zero_sll", OP_SLL, 32'h1234_5678, 5'd0, 32'h1234_5678, ZERO_LAT, ZERO_BUSY);
    run_op("zero_sra", OP_SRA, 32'h8765_4321, 5'd0, 32'h8765_4321, ZERO_LAT, ZERO_BUSY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
